// File: rtl/param_datapath.sv
// param_datapath: parametrised single-bus datapath with iterative signed mul/div unit
module param_datapath #(
  parameter int DATA_W = 32,
  parameter int NREGS = 16,
  localparam int RW = $clog2(NREGS),
  localparam int SW = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inport_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] immediate,
  input  logic [3:0]        bus_src,
  input  logic [RW-1:0]     rsel_out,
  input  logic [RW-1:0]     rsel_in,
  input  logic              ba_out,
  input  logic              rin,
  input  logic              hi_in,
  input  logic              lo_in,
  input  logic              y_in,
  input  logic              z_in,
  input  logic              pc_in,
  input  logic              ir_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              inport_in,
  input  logic              outport_in,
  input  logic [1:0]        mdr_src,
  input  logic [3:0]        alu_op,
  input  logic              alu_start,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] pc_q,
  output logic [DATA_W-1:0] ir_q,
  output logic [DATA_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic [DATA_W-1:0] outport_q,
  output logic              busy,
  output logic              done,
  output logic              div0
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] r_q [NREGS];
  logic [DATA_W-1:0] hi_q, lo_q, y_q, inport_q;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic [DATA_W:0] acc_q, acc_d, m_q, m_d, sum, sh, trial;
  logic [DATA_W-1:0] qr_q, qr_d, alu_res, mdr_d, abs_a, abs_b, qv;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] s;
  logic q1_q, q1_d, mul_q, mul_d, sa_q, sa_d, sq_q, sq_d, dz_q, dz_d, done_d, div0_d, start;
  always_comb begin
    case (bus_src)
      4'd0: bus = (ba_out && rsel_out == '0) ? '0 : r_q[rsel_out];
      4'd1: bus = hi_q;
      4'd2: bus = lo_q;
      4'd3: bus = z_q[2*DATA_W-1:DATA_W];
      4'd4: bus = z_q[DATA_W-1:0];
      4'd5: bus = pc_q;
      4'd6: bus = mdr_q;
      4'd7: bus = inport_q;
      4'd8: bus = immediate;
      default: bus = '0;
    endcase
  end
  assign s = bus[SW-1:0];
  always_comb begin
    case (alu_op)
      4'd0: alu_res = y_q + bus;
      4'd1: alu_res = y_q - bus;
      4'd2: alu_res = y_q & bus;
      4'd3: alu_res = y_q | bus;
      4'd4: alu_res = y_q >> s;
      4'd5: alu_res = $signed(y_q) >>> s;
      4'd6: alu_res = y_q << s;
      4'd7: alu_res = (y_q >> s) | (y_q << (DATA_W - s));
      4'd8: alu_res = (y_q << s) | (y_q >> (DATA_W - s));
      4'd9: alu_res = -bus;
      4'd10: alu_res = ~bus;
      4'd11: alu_res = bus + DATA_W'(1);
      default: alu_res = '0;
    endcase
  end
  assign mdr_d = mdr_src == 2'd0 ? bus : mdr_src == 2'd1 ? mem_rdata : mdr_src == 2'd2 ? immediate : '0;
  assign abs_a = y_q[DATA_W-1] ? -y_q : y_q;
  assign abs_b = bus[DATA_W-1] ? -bus : bus;
  assign start = state_q == IDLE && alu_start && (alu_op == 4'd12 || alu_op == 4'd13);
  assign sum = (qr_q[0] && !q1_q) ? acc_q - m_q : (!qr_q[0] && q1_q) ? acc_q + m_q : acc_q;
  assign sh = {acc_q[DATA_W-1:0], qr_q[DATA_W-1]};
  assign trial = sh - m_q;
  assign qv = sq_q ? -qr_q : qr_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    qr_d = qr_q;
    q1_d = q1_q;
    m_d = m_q;
    mul_d = mul_q;
    sa_d = sa_q;
    sq_d = sq_q;
    dz_d = dz_q;
    done_d = 1'b0;
    div0_d = div0;
    z_d = z_q;
    if (state_q == IDLE && z_in) z_d = {{DATA_W{1'b0}}, alu_res};
    if (start) begin
      state_d = RUN;
      cnt_d = CW'(DATA_W);
      mul_d = alu_op == 4'd12;
      acc_d = '0;
      q1_d = 1'b0;
      qr_d = mul_d ? bus : abs_a;
      m_d = mul_d ? {y_q[DATA_W-1], y_q} : {1'b0, abs_b};
      sa_d = y_q[DATA_W-1];
      sq_d = y_q[DATA_W-1] ^ bus[DATA_W-1];
      dz_d = bus == '0;
      if (!mul_d && !dz_d) div0_d = 1'b0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? FIN : RUN;
      if (mul_q) {acc_d, qr_d, q1_d} = {sum[DATA_W], sum, qr_q};
      else begin
        acc_d = trial[DATA_W] ? sh : trial;
        qr_d = {qr_q[DATA_W-2:0], ~trial[DATA_W]};
      end
    end else if (state_q == FIN) begin
      state_d = IDLE;
      done_d = 1'b1;
      z_d = mul_q ? {acc_q[DATA_W-1:0], qr_q} : {sa_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0], dz_q ? {DATA_W{1'b1}} : qv};
      if (!mul_q && dz_q) div0_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
      {hi_q, lo_q, y_q, z_q, pc_q, ir_q, mar_q, mdr_q, inport_q, outport_q} <= '0;
      {acc_q, qr_q, q1_q, m_q, mul_q, sa_q, sq_q, dz_q, cnt_q} <= '0;
      state_q <= IDLE;
      done <= 1'b0;
      div0 <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      qr_q <= qr_d;
      q1_q <= q1_d;
      m_q <= m_d;
      mul_q <= mul_d;
      sa_q <= sa_d;
      sq_q <= sq_d;
      dz_q <= dz_d;
      done <= done_d;
      div0 <= div0_d;
      z_q <= z_d;
      if (rin) r_q[rsel_in] <= bus;
      if (hi_in) hi_q <= bus;
      if (lo_in) lo_q <= bus;
      if (y_in) y_q <= bus;
      if (pc_in) pc_q <= bus;
      if (ir_in) ir_q <= bus;
      if (mar_in) mar_q <= bus;
      if (mdr_in) mdr_q <= mdr_d;
      if (inport_in) inport_q <= inport_data;
      if (outport_in) outport_q <= bus;
    end
  end
endmodule

// File: doc/param_datapath.md
# param_datapath

Parametrised single-bus processor datapath: next generation of the 32-bit, 16-register datapath. Data width and general-register count are set by parameters; bus sourcing is encoded rather than one-hot. Adds an iterative signed multiply/divide unit with a start/busy/done handshake and a divide-by-zero flag. Sits between the control unit (which drives all enables and selects) and the memory/IO blocks.

## Interface
- DATA_W, 32, datapath width; any value ≥ 8
- NREGS, 16, general registers R0..R(NREGS-1); power of 2, 2..32
- RW = $clog2(NREGS) (derived), SW = $clog2(DATA_W) (derived)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; 0 at a rising edge clears all state
- inport_data / mem_rdata / immediate  in  DATA_W each  external port, memory read data, sign-extended constant
- bus_src  in  4  bus driver: 0 REG, 1 HI, 2 LO, 3 ZHI, 4 ZLO, 5 PC, 6 MDR, 7 INPORT, 8 IMM; 9–15 drive 0
- rsel_out / rsel_in  in  RW each  register read / write index
- ba_out  in  1  forces bus to 0 when bus_src=REG and rsel_out=0
- rin, hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in, inport_in, outport_in  in  1 each  load enables
- mdr_src  in  2  MDR input: 0 bus, 1 mem_rdata, 2 immediate, 3 zero
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 INC, 12 MUL, 13 DIV; 14–15 give 0
- alu_start  in  1  launches MUL/DIV; ignored for other ops
- bus  out  DATA_W  current bus value (combinational)
- pc_q, ir_q, mar_q, mdr_q, outport_q  out  DATA_W each  register contents (mdr_q is memory write data)
- busy, done, div0  out  1 each  mul/div active; one-cycle completion pulse; last DIV had zero divisor

## Operation
- Registers: R0..R(NREGS-1), HI, LO, Y, Z (2·DATA_W: ZHI/ZLO), PC, IR, MAR, MDR, INPORT, OUTPORT. Each loads from bus when its enable is high, except MDR (loads from mdr_src mux), INPORT (loads from inport_data) and Z (loads from the ALU).
- The bus is a pure mux of bus_src; there is no tristate.
- Single-cycle ops: A = Y, B = bus. With z_in=1, Z gets {0, result}. ADD/SUB wrap modulo 2^DATA_W. Shift/rotate amount = B[SW-1:0]. SHRA replicates the sign bit. NEG = −B, NOT = ~B, INC = B+1 (A unused).
- MUL: signed radix-2 Booth, one step per cycle. Z = full 2·DATA_W product.
- DIV: signed restoring, one step per cycle. ZLO = quotient truncated toward zero. ZHI = remainder with the sign of the dividend (A).
- DIV by zero: ZLO = all ones, ZHI = A, div0 = 1. div0 clears on the next successful DIV start.
- Mul/div FSM:
  - IDLE → RUN on alu_start with alu_op ∈ {12,13}. Y and bus are captured at that edge.
  - RUN counts DATA_W steps, then goes to FIN.
  - FIN writes Z, pulses done, returns to IDLE.
- While busy:
  - alu_start is ignored.
  - z_in is ignored, so Z is protected.
  - All other register loads and bus transfers proceed normally; Y and bus may change without affecting the operation.
- Simultaneous events: rin with rsel_in=0 writes R0 normally (ba_out affects reads only). If rsel_in equals a register also driving the bus, the register reloads its own value.

## Timing
- Reset (reset=0 at an edge): every register is 0; FSM is IDLE; busy = done = div0 = 0. A reset during RUN aborts the operation and leaves Z = 0.
- Register loads take effect at the edge where the enable is high; the new value is visible on the bus in the next cycle.
- Single-cycle ALU latency is 1 edge (z_in edge).
- MUL/DIV:
  - alu_start sampled at edge k → busy = 1 after edge k.
  - Z valid, done = 1 and busy = 0 after edge k + DATA_W + 1.
  - done lasts exactly one cycle.
  - A new alu_start is accepted in the done cycle, giving back-to-back operations.

## Test plan
- Reset mid-MUL: load R3=0x1234 and start a MUL; assert reset=0 for one edge after 5 cycles → all registers 0, busy=0, done=0, Z=0.
- MUL (DATA_W=32): Y=0xFFFFFFFD (−3), bus=7, alu_start → done exactly 33 cycles later; ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB. z_in pulsed mid-run leaves Z unchanged.
- DIV: 17 / −5 → ZLO=0xFFFFFFFD, ZHI=2. Then −17 / 5 → ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFE. Then 9 / 0 → ZLO=0xFFFFFFFF, ZHI=9, div0=1. Then 8 / 2 → div0=0.
- Single-cycle ops: Y=0x80000001, bus=1:
  - ROL → ZLO=0x00000003
  - SHRA → 0xC0000000
  - SUB → 0x80000000
  - ZHI=0 in every case
- Bus and BA: R0=0xAA, ba_out=1, bus_src=REG, rsel_out=0 → bus=0; with ba_out=0 → bus=0xAA. mdr_src=1 with mem_rdata=0x55, mdr_in → mdr_q=0x55.
- Parametrisation: DATA_W=16, NREGS=8 → MUL 0x8000 × 0x8000 gives Z=0x40000000 with done at 17 cycles; rsel_in=7 writes R7; bus_src=12 drives 0.
